// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
// Default geometry, controller state encoding and byte-address field helpers.
package dcache_pkg;

    localparam int unsigned DEF_ADDR_W         = 32;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_LINES          = 64;
    localparam int unsigned DEF_WORDS_PER_LINE = 4;

    // Field widths for the default geometry
    localparam int unsigned INDEX_W = $clog2(DEF_LINES);
    localparam int unsigned WORD_W  = $clog2(DEF_WORDS_PER_LINE);
    localparam int unsigned TAG_W   = DEF_ADDR_W - INDEX_W - WORD_W - 2;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StWrite
    } dcache_state_e;

    // Generic right-justified bit field of a byte address
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (addr >> lsb) & mask;
    endfunction

    // Word-within-line select; the two byte-offset bits are skipped
    function automatic logic [31:0] word_field(input logic [31:0] addr,
                                               input int unsigned word_w);
        return addr_field(addr, 2, word_w);
    endfunction

    function automatic logic [31:0] index_field(input logic [31:0] addr,
                                                input int unsigned word_w,
                                                input int unsigned index_w);
        return addr_field(addr, 2 + word_w, index_w);
    endfunction

    function automatic logic [31:0] tag_field(input logic [31:0] addr,
                                              input int unsigned word_w,
                                              input int unsigned index_w,
                                              input int unsigned tag_w);
        return addr_field(addr, 2 + word_w + index_w, tag_w);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the data cache.
// Reads are asynchronous, writes synchronous; valid bits clear asynchronously on reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned INDEX_BITS     = INDEX_W,
    parameter int unsigned WORD_BITS      = WORD_W,
    parameter int unsigned TAG_BITS       = TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  data_we,
    input  logic [WORD_BITS-1:0]  data_word,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic                  line_we,
    input  logic                  line_valid,
    input  logic [TAG_BITS-1:0]   line_tag
);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES*WORDS_PER_LINE];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

    // Valid bits: the only storage that must come out of reset in a known state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_index] <= line_valid;
        end
    end

    // Tag and data RAM writes
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[wr_index] <= line_tag;
        end
        if (data_we) begin
            data_mem[{wr_index, data_word}] <= data_wdata;
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses refill a whole line over the req/ack word bus; Stall holds the core meanwhile.
// Optional hit/miss counters are built when DCACHE_PERF_EN is defined.
module data_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DCACHE_PERF_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_BITS = $clog2(LINES);
    localparam int unsigned IDX_LSB    = 2 + WORD_BITS;
    localparam int unsigned TAG_BITS   = ADDR_W - INDEX_BITS - IDX_LSB;
    localparam logic [WORD_BITS-1:0] CNT_LAST = WORD_BITS'(WORDS_PER_LINE - 1);

    dcache_state_e          state_q;
    logic [WORD_BITS-1:0]   cnt_q;
    logic [WORD_BITS-1:0]   cnt_inc;
    logic [WORD_BITS-1:0]   addr_word;
    logic [INDEX_BITS-1:0]  addr_index;
    logic [TAG_BITS-1:0]    addr_tag;
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [DATA_W-1:0]      rd_data;
    logic                   hit;
    logic                   is_read;
    logic                   read_done;
    logic                   refill_last;
    logic                   data_we;
    logic [WORD_BITS-1:0]   data_word;
    logic [DATA_W-1:0]      data_wdata;
    logic                   line_we;

    assign addr_word  = WORD_BITS'(word_field(32'(Addr), WORD_BITS));
    assign addr_index = INDEX_BITS'(index_field(32'(Addr), WORD_BITS, INDEX_BITS));
    assign addr_tag   = TAG_BITS'(tag_field(32'(Addr), WORD_BITS, INDEX_BITS, TAG_BITS));

    assign cnt_inc     = cnt_q + WORD_BITS'(1);
    assign hit         = rd_valid && (rd_tag == addr_tag);
    // A simultaneous read and write is handled as a write
    assign is_read     = MemRead && !MemWrite;
    assign read_done   = (state_q == StIdle) && is_read && hit;
    assign refill_last = (state_q == StRefill) && mem_ack && (cnt_q == CNT_LAST);

    // Core-facing outputs: hits complete with zero stall; a write frees the core in its ack cycle
    always_comb begin
        ReadData = read_done ? rd_data : '0;
        Stall    = 1'b0;
        unique case (state_q)
            StIdle:   Stall = MemWrite || (MemRead && !hit);
            StRefill: Stall = 1'b1;
            StWrite:  Stall = !mem_ack;
            default:  Stall = 1'b0;
        endcase
    end

    // Array write controls: refill words, write-hit updates, line (in)validation
    always_comb begin
        data_we    = ((state_q == StRefill) && mem_ack) || ((state_q == StWrite) && mem_ack && hit);
        data_word  = (state_q == StRefill) ? cnt_q : addr_word;
        data_wdata = (state_q == StRefill) ? mem_rdata : WriteData;
        // Invalidate on miss entry so an aborted refill never leaves a half-filled valid line
        line_we    = ((state_q == StIdle) && is_read && !hit) || refill_last;
    end

    dcache_array #(
        .DATA_W         (DATA_W),
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .INDEX_BITS     (INDEX_BITS),
        .WORD_BITS      (WORD_BITS),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index   (addr_index),
        .rd_word    (addr_word),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_index   (addr_index),
        .data_we    (data_we),
        .data_word  (data_word),
        .data_wdata (data_wdata),
        .line_we    (line_we),
        .line_valid (refill_last),
        .line_tag   (addr_tag)
    );

    // Controller FSM with registered bus outputs, held stable while mem_req is up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (MemWrite) begin
                        state_q   <= StWrite;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= WriteData;
                    end else if (MemRead && !hit) begin
                        state_q  <= StRefill;
                        cnt_q    <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {Addr[ADDR_W-1:IDX_LSB], {WORD_BITS{1'b0}}, 2'b00};
                    end
                end
                StRefill: begin
                    if (mem_ack) begin
                        cnt_q <= cnt_inc;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= StIdle;
                            mem_req <= 1'b0;
                        end else begin
                            mem_addr <= {Addr[ADDR_W-1:IDX_LSB], cnt_inc, 2'b00};
                        end
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        state_q <= StIdle;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DCACHE_PERF_EN
    logic refilled_q;

    // Count completed reads; the hit that closes a refill is that refill's miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            refilled_q <= 1'b0;
        end else begin
            refilled_q <= refill_last;
            if (read_done) begin
                if (refilled_q) begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                end else begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: a word-bus memory responder checks every bus transaction
// against an expected-transaction queue; core reads are checked against a queue of
// expected load data when Stall falls.
module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          ack_delay   = 2;
    int          ack_count   = 0;
    bus_t        bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem_store [logic [31:0]];

    always #5 clk = ~clk;

    data_cache_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef DCACHE_PERF_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
`endif
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: acks ack_delay cycles after it first sees mem_req, then checks the transaction
    initial begin : responder
        bit   busy;
        int   cnt;
        bus_t exp;
        busy = 0;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req !== 1'b1) begin
                busy = 0;
            end else if (!busy) begin
                busy = 1;
                cnt = ack_delay;
            end else begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    mem_ack = 1'b1;
                    ack_count++;
                    vectors++;
                    if (bus_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL bus_unexpected: got we=%0b addr=%h wdata=%h, want no transaction",
                                 mem_we, mem_addr, mem_wdata);
                    end else begin
                        exp = bus_q.pop_front();
                        if (mem_we !== exp.we || mem_addr !== exp.addr ||
                            (exp.we && mem_wdata !== exp.data)) begin
                            miscompares++;
                            $display("FAIL bus_txn: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, exp.we, exp.addr, exp.data);
                        end
                    end
                    if (mem_we) mem_store[mem_addr] = mem_wdata;
                    else mem_rdata = word_at(mem_addr);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000ns");
        $fatal(1, "timeout");
    end

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) bus_q.push_back('{1'b0, base + 32'(i * 4), 32'h0});
    endtask

    // One core access held until Stall falls; checks stall length and load data
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int exp_stalls, input string name);
        int          n;
        logic [31:0] e;
        MemRead = !we;
        MemWrite = we;
        Addr = a;
        WriteData = wdata;
        if (!we) rd_q.push_back(exp_rd);
        n = 0;
        @(negedge clk);
        while (Stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL %s_timeout: got Stall still 1 after %0d cycles, want release", name, n);
        end else if (n != exp_stalls) begin
            miscompares++;
            $display("FAIL %s_stalls: got %0d, want %0d", name, n, exp_stalls);
        end
        if (!we) begin
            e = rd_q.pop_front();
            vectors++;
            if (ReadData !== e) begin
                miscompares++;
                $display("FAIL %s_rdata: got %h, want %h", name, ReadData, e);
            end
        end
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        Addr = '0;
        WriteData = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({Stall, mem_req, mem_we} !== 3'b000 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || ReadData !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got stall=%0b req=%0b we=%0b addr=%h wdata=%h rd=%h, want all 0",
                     Stall, mem_req, mem_we, mem_addr, mem_wdata, ReadData);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Cold miss: 4 words, each acked 2 cycles after req -> 1 + 4*3 stall cycles
    task automatic test_read_miss();
        push_refill(32'h100);
        access(1'b0, 32'h100, '0, 32'hA0, 13, "read_miss");
    endtask

    task automatic test_read_hit();
        int base;
        base = ack_count;
        access(1'b0, 32'h108, '0, 32'hA2, 0, "read_hit");
        vectors++;
        if (ack_count != base || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL read_hit_bus: got acks=%0d req=%0b, want acks=0 req=0", ack_count - base, mem_req);
        end
`ifdef DCACHE_PERF_EN
        vectors++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL perf_cnt: got hit=%0d miss=%0d, want hit=1 miss=1", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_write_hit();
        bus_q.push_back('{1'b1, 32'h104, 32'hDEAD});
        access(1'b1, 32'h104, 32'hDEAD, '0, 3, "write_hit");
        access(1'b0, 32'h104, '0, 32'hDEAD, 0, "write_hit_readback");
    endtask

    // No write-allocate: the following read must still refill
    task automatic test_write_miss();
        bus_q.push_back('{1'b1, 32'h2000, 32'h55});
        access(1'b1, 32'h2000, 32'h55, '0, 3, "write_miss");
        push_refill(32'h2000);
        access(1'b0, 32'h2000, '0, 32'h55, 13, "write_miss_refill");
    endtask

    // 0x500 and 0x100 share index 0x10
    task automatic test_conflict();
        push_refill(32'h500);
        access(1'b0, 32'h500, '0, 32'hC0DE_0500, 13, "conflict_evict");
        push_refill(32'h100);
        access(1'b0, 32'h100, '0, 32'hA0, 13, "conflict_remiss");
    endtask

    task automatic test_back_to_back();
        access(1'b0, 32'h10C, '0, 32'hA3, 0, "b2b_0");
        access(1'b0, 32'h104, '0, 32'hDEAD, 0, "b2b_1");
        access(1'b0, 32'h100, '0, 32'hA0, 0, "b2b_2");
    endtask

    task automatic test_reset_mid_refill();
        int base;
        int n;
        push_refill(32'h300);
        MemRead = 1'b1;
        Addr = 32'h300;
        base = ack_count;
        n = 0;
        @(negedge clk);
        while (ack_count < base + 2 && n < 200) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_refill_req: got %0b, want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drop_req: got %0b, want 0", mem_req);
        end
        MemRead = 1'b0;
        bus_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_refill(32'h100);
        access(1'b0, 32'h100, '0, 32'hA0, 13, "post_reset_refill");
        push_refill(32'h300);
        access(1'b0, 32'h300, '0, 32'hC0DE_0300, 13, "aborted_line_invalid");
    endtask

    initial begin : main
        for (int i = 0; i < 4; i++) mem_store[32'h100 + 32'(i * 4)] = 32'hA0 + 32'(i);
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_back_to_back();
        test_reset_mid_refill();
        repeat (4) @(negedge clk);
        vectors++;
        if (bus_q.size() != 0) begin
            miscompares++;
            $display("FAIL bus_drain: got %0d pending transactions, want 0", bus_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
